imem_loader: RTL
================

# imem_loader

Byte-stream program loader that writes the instruction memory's write port so a new program can be installed without a rebuild. It accepts a length-prefixed little-endian byte stream (typically from a UART receiver) and assembles 32-bit instruction words. It writes them to consecutive word addresses from 0, then pads every remaining address with the halt instruction. While it runs it holds the core in reset, so fetch never sees a partially written program.

## Interface
Parameters:
- ADDR_WIDTH, 8: word-address width; memory depth is 2**ADDR_WIDTH words.
- HALT_WORD, 32'h00000063: pad value (beq x0, x0, 0).

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a load.
- byte_valid  input  1  stream byte present.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader accepts byte this cycle.
- wr_en  output  1  memory write strobe, one cycle per word.
- wr_addr  output  ADDR_WIDTH  word address of write.
- wr_data  output  32  word to write.
- cpu_hold  output  1  core held in reset while high.
- busy  output  1  load in progress (any state but IDLE/ERR).
- done  output  1  one-cycle pulse on successful completion.
- error  output  1  sticky failure flag.
- word_count  output  ADDR_WIDTH+1  number of stream words written in the current/last load.

## Operation
- Byte transfer occurs when byte_valid && byte_ready. byte_ready is 1 only in HDR, LOAD and CSUM.
- States and transitions:
  - IDLE: wait for start.
  - HDR: receive 2 bytes forming N, low byte first.
  - LOAD: receive 4*N bytes and assemble words.
  - FILL: write HALT_WORD to addresses N .. 2**ADDR_WIDTH-1.
  - CSUM: present only when the checksum feature is compiled in.
  - DONE: assert done, return to IDLE.
  - ERR: failure state, left only by start or reset.
- IDLE: start -> HDR, cpu_hold=1, word_count=0, error=0.
- HDR: when the second byte is accepted, check N.
  - N==0 or N>2**ADDR_WIDTH -> ERR.
  - Otherwise -> LOAD.
- LOAD: bytes are assembled little-endian; byte 0 goes to [7:0].
  - Every 4th accepted byte issues a write at address word_count, and word_count increments.
  - After word N: -> FILL, or -> CSUM if enabled.
  - If N==2**ADDR_WIDTH, FILL is skipped (-> DONE, or -> CSUM).
- FILL: one write per cycle with wr_data=HALT_WORD. The last address is 2**ADDR_WIDTH-1, then -> DONE.
- DONE: done=1 for one cycle, cpu_hold=0, -> IDLE.
- ERR: error=1, cpu_hold stays 1, no writes.
  - start in ERR clears error and -> HDR.
- start while busy is ignored.
- A gap in byte_valid at any point stalls the state; there is no timeout.

## Timing
- Reset values: byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=0, busy=0, done=0, error=0, word_count=0, state IDLE.
- All outputs are registered.
- start -> HDR with byte_ready=1 on the next cycle.
- Stream write latency: wr_en/wr_addr/wr_data are valid the cycle after the 4th byte of the word is accepted.
- FILL throughput is 1 word/cycle, starting the cycle after the last LOAD write (or after the CSUM accept).
- done is high one cycle after the final FILL write, together with the falling edge of cpu_hold.
- A byte arriving on the same cycle as start in IDLE is not accepted (byte_ready=0).
- Asserting rst_n low mid-load aborts immediately with reset values. Memory keeps whatever was already written.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - After the last data byte, CSUM accepts one byte and compares it with the running XOR of all 4*N data bytes. Header bytes are excluded.
  - Match -> FILL/DONE; mismatch -> ERR.
  - Data writes already performed stay in memory.
- Undefined: no CSUM state; LOAD goes directly to FILL/DONE and no extra byte is consumed.

## Structure
- Shared package imem_pkg:
  - state enum (IDLE, HDR, LOAD, FILL, CSUM, DONE, ERR).
  - HALT_WORD constant.
  - default ADDR_WIDTH.
- Optional sub-module byte_packer: assembles 4 bytes into 32 bits with a word-complete strobe. Its byte index wraps 3->0 and is reset on start.

## Test plan
- ADDR_WIDTH=2, start, then stream 02 00, 13 00 00 00, 93 00 10 00.
  - Writes: 0<-00000013, 1<-00100093, 2<-00000063, 3<-00000063.
  - done pulses once, cpu_hold falls, word_count=2.
- Header 00 00 -> ERR: error=1, no wr_en, cpu_hold=1. A following start with a valid header completes normally and clears error.
- ADDR_WIDTH=2, header 04 00 with 16 bytes -> 4 writes, no FILL writes, done. Header 05 00 -> ERR.
- byte_valid toggled every other cycle during LOAD -> identical write sequence to the back-to-back case; no bytes are dropped or duplicated.
- rst_n low after 5 data bytes -> all outputs at reset values next cycle. A new start then restarts from address 0 with the byte index reset.
- IMEM_LOADER_CHECKSUM_EN: stream 01 00, 13 00 00 00.
  - Checksum byte 13 -> done.
  - Checksum byte 12 -> ERR after the word-0 write, with no FILL writes.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction-memory loader.
package imem_pkg;

    localparam int          DEF_ADDR_WIDTH    = 8;
    localparam logic [31:0] DEFAULT_HALT_WORD = 32'h0000_0063; // beq x0, x0, 0

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LOAD,
        S_FILL,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

endpackage

// File: rtl/imem_loader_packer.sv
// Assembles a little-endian byte stream into 32-bit words; word_done strobes
// combinationally on the 4th byte so the caller can register the write.
module byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    output logic        word_done,
    output logic [31:0] word
);

    logic [1:0]  idx;
    logic [23:0] lo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= 2'd0;
            lo  <= 24'd0;
        end else if (clear) begin
            idx <= 2'd0;
        end else if (byte_en) begin
            idx <= idx + 2'd1;
            case (idx)
                2'd0:    lo[7:0]   <= byte_data;
                2'd1:    lo[15:8]  <= byte_data;
                2'd2:    lo[23:16] <= byte_data;
                default: ;
            endcase
        end
    end

    assign word_done = byte_en && (idx == 2'd3);
    assign word      = {byte_data, lo};

endmodule

// File: rtl/imem_loader.sv
// Program loader: length-prefixed byte stream -> imem writes, halt padding,
// core held in reset meanwhile. Define IMEM_LOADER_CHECKSUM_EN for XOR check.
module imem_loader
    import imem_pkg::*;
#(
    parameter int          ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter logic [31:0] HALT_WORD  = DEFAULT_HALT_WORD
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [31:0]           wr_data,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   word_count
);

    localparam int              AW      = ADDR_WIDTH;
    localparam logic [AW:0]     DEPTH   = {1'b1, {AW{1'b0}}};
    localparam logic [15:0]     DEPTH16 = 16'(DEPTH);
    localparam logic [AW:0]     CNT_ONE = 1;
    localparam logic [AW-1:0]   PTR_ONE = 1;

    state_t        state, state_d;
    logic          accept, start_ok;
    logic          hdr_phase;
    logic [7:0]    hdr_lo;
    logic [15:0]   hdr_n;
    logic          hdr_bad;
    logic [AW:0]   n;
    logic [AW-1:0] fill_ptr;
    logic          word_done, last_word, skip_fill;
    logic [31:0]   word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]    csum;
`endif

    assign accept    = byte_valid && byte_ready;
    assign start_ok  = start && (state == S_IDLE || state == S_ERR);
    assign hdr_n     = {byte_data, hdr_lo};
    assign hdr_bad   = (hdr_n == 16'd0) || (hdr_n > DEPTH16);
    assign last_word = word_done && ((word_count + CNT_ONE) == n);
    assign skip_fill = (n == DEPTH);

    byte_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (start_ok),
        .byte_en   (accept && state == S_LOAD),
        .byte_data (byte_data),
        .word_done (word_done),
        .word      (word)
    );

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (start) state_d = S_HDR;
            S_HDR:   if (accept && hdr_phase) state_d = hdr_bad ? S_ERR : S_LOAD;
            S_LOAD: begin
                if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = S_CSUM;
`else
                    state_d = skip_fill ? S_DONE : S_FILL;
`endif
                end
            end
            S_FILL:  if (&fill_ptr) state_d = S_DONE;
            S_CSUM: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (accept)
                    state_d = (byte_data != csum) ? S_ERR : (skip_fill ? S_DONE : S_FILL);
`else
                state_d = S_ERR;
`endif
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   if (start) state_d = S_HDR;
            default: state_d = S_IDLE;
        endcase
    end

    // Status flags are registered from the next state so they line up with it;
    // done lags one cycle so it follows the final write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state      <= state_d;
            byte_ready <= state_d inside {S_HDR, S_LOAD, S_CSUM};
            busy       <= !(state_d inside {S_IDLE, S_ERR});
            cpu_hold   <= (state_d != S_IDLE);
            done       <= (state == S_DONE);
            error      <= (state_d == S_ERR);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            word_count <= '0;
            hdr_phase  <= 1'b0;
            hdr_lo     <= 8'd0;
            n          <= '0;
            fill_ptr   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum       <= 8'd0;
`endif
        end else begin
            wr_en <= 1'b0;
            if (start_ok) begin
                word_count <= '0;
                hdr_phase  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum       <= 8'd0;
`endif
            end
            if (state == S_HDR && accept) begin
                if (!hdr_phase) begin
                    hdr_lo    <= byte_data;
                    hdr_phase <= 1'b1;
                end else begin
                    n        <= hdr_n[AW:0];
                    fill_ptr <= hdr_n[AW-1:0];
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (state == S_LOAD && accept)
                csum <= csum ^ byte_data;
`endif
            if (word_done) begin
                wr_en      <= 1'b1;
                wr_addr    <= word_count[AW-1:0];
                wr_data    <= word;
                word_count <= word_count + CNT_ONE;
            end
            if (state == S_FILL) begin
                wr_en    <= 1'b1;
                wr_addr  <= fill_ptr;
                wr_data  <= HALT_WORD;
                fill_ptr <= fill_ptr + PTR_ONE;
            end
        end
    end

endmodule
